// File: rtl/fir_out_requantizer.sv
// Captures fir_out once per fold frame, requantises 22b(.18) to 12b(.10) with round-half-up and saturation.
// Capture-to-out_valid is 2 cycles; when the FIFO is full and not popping, new samples are dropped and counted.
module fir_out_requantizer #(
    parameter int IN_W      = 22,
    parameter int OUT_W     = 12,
    parameter int SHIFT     = 8,
    parameter int FOLD      = 5,
    parameter int CAP_PHASE = 1,
    parameter int DEPTH     = 4
) (
    input  logic                    i_clk100,
    input  logic                    i_reset,
    input  logic signed [IN_W-1:0]  i_fir_out,
    output logic signed [OUT_W-1:0] o_out_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_sat_flag,
    output logic [7:0]              o_drop_cnt
);

    localparam int RQ_W  = IN_W - SHIFT + 1;
    localparam int PH_W  = (FOLD > 1) ? $clog2(FOLD) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]         r_phase;
    logic signed [IN_W-1:0]  r_stage;
    logic                    r_stage_vld;
    logic [OUT_W-1:0]        r_q;
    logic                    r_q_vld;
    logic                    r_sat;
    logic [7:0]              r_drop;
    logic [OUT_W-1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;

    logic signed [RQ_W-1:0]  w_trunc;
    logic signed [RQ_W-1:0]  w_rbit;
    logic signed [RQ_W-1:0]  w_round;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic [OUT_W-1:0]        w_clamped;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // Phase counter runs free from reset release; capture happens once per frame.
    always_ff @(posedge i_clk100) begin
        if (i_reset) begin
            r_phase     <= '0;
            r_stage_vld <= 1'b0;
            r_stage     <= '0;
        end else begin
            if (r_phase == PH_W'(FOLD - 1)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
            r_stage_vld <= (r_phase == PH_W'(CAP_PHASE));
            if (r_phase == PH_W'(CAP_PHASE)) begin
                r_stage <= i_fir_out;
            end
        end
    end

    // The dropped MSB half-LSB is added back so ties round toward +inf; the extra bit avoids overflow.
    assign w_trunc   = RQ_W'(r_stage >>> SHIFT);
    assign w_rbit    = {{(RQ_W-1){1'b0}}, r_stage[SHIFT-1]};
    assign w_round   = w_trunc + w_rbit;
    assign w_sat_hi  = (w_round > OUT_MAX);
    assign w_sat_lo  = (w_round < OUT_MIN);
    assign w_clamped = w_sat_hi ? OUT_MAX : (w_sat_lo ? OUT_MIN : w_round[OUT_W-1:0]);

    always_ff @(posedge i_clk100) begin
        if (i_reset) begin
            r_q_vld <= 1'b0;
            r_q     <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_q_vld <= r_stage_vld;
            if (r_stage_vld) begin
                r_q <= w_clamped;
                if (w_sat_hi || w_sat_lo) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = (r_count != '0) && i_out_ready;
    assign w_push = r_q_vld && (!w_full || w_pop);
    assign w_drop = r_q_vld && w_full && !w_pop;

    always_ff @(posedge i_clk100) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_q;
        end
    end

    always_ff @(posedge i_clk100) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign o_out_valid = (r_count != '0);
    assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;
    assign o_sat_flag  = r_sat;
    assign o_drop_cnt  = r_drop;

endmodule
